// File: rtl/noc_pkg.sv
// Shared definitions for the NoC port arbiter: mesh link widths and the
// arbiter FSM state encoding.
package noc_pkg;

  // Shared mesh link parameters; the arbiter's width defaults follow these.
  localparam int NOC_TDATA_WIDTH = 32;
  localparam int NOC_TDEST_WIDTH = 4;

  // IDLE: choosing the next owner.  LOCKED: one requester owns the port
  // until its TLAST beat is accepted.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/noc_port_arbiter_rr_arbiter.sv
// Combinational round-robin select: picks the first asserted request at or
// after ptr, wrapping circularly, and returns it as a one-hot vector.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTRW    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTRW-1:0]    ptr,
  output logic [NUM_REQ-1:0] sel
);

  logic [PTRW:0] pos;
  logic          found;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (PTRW+1)'(k);
      if (pos >= (PTRW+1)'(NUM_REQ)) begin
        pos = pos - (PTRW+1)'(NUM_REQ);
      end
      if (!found && req[pos[PTRW-1:0]]) begin
        sel[pos[PTRW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC router input port among
// NUM_REQ AXI-Stream requesters.  The grant is held from the first beat of a
// packet until its TLAST beat is accepted, so packets never interleave.  A
// 2-entry FIFO sits in front of the router so the output is registered and
// one beat per cycle is sustained.
//
// Handshake: on every AXI-Stream link a beat transfers on a rising edge
// where TVALID and TREADY are both high; a source holds TVALID and its
// payload stable until that happens, and TREADY may be asserted
// independently of TVALID.
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter int TDATAW  = NOC_TDATA_WIDTH,
  parameter int TDESTW  = NOC_TDEST_WIDTH,
  parameter int NUM_REQ = 2,
  localparam int PTRW   = $clog2(NUM_REQ)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         REQ_EN,
  input  logic [NUM_REQ-1:0]         AXIS_S_TVALID,
  output logic [NUM_REQ-1:0]         AXIS_S_TREADY,
  input  logic [NUM_REQ*TDATAW-1:0]  AXIS_S_TDATA,
  input  logic [NUM_REQ-1:0]         AXIS_S_TLAST,
  input  logic [NUM_REQ*TDESTW-1:0]  AXIS_S_TDEST,
  output logic                       AXIS_M_TVALID,
  input  logic                       AXIS_M_TREADY,
  output logic [TDATAW-1:0]          AXIS_M_TDATA,
  output logic                       AXIS_M_TLAST,
  output logic [TDESTW-1:0]          AXIS_M_TDEST,
  output logic [NUM_REQ-1:0]         GRANT,
  output logic                       BUSY,
  output arb_state_t                 dbg_state,
  output logic [PTRW-1:0]            dbg_rr_ptr
);

  // Arbitration state
  arb_state_t          state;
  logic [NUM_REQ-1:0]  grant;
  logic [PTRW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  cand;
  logic [NUM_REQ-1:0]  sel;

  // Beat offered by the current owner
  logic [PTRW-1:0]     gidx;
  logic                in_valid;
  logic [TDATAW-1:0]   in_data;
  logic                in_last;
  logic [TDESTW-1:0]   in_dest;

  // Output FIFO: head entry drives M_T* directly, tail holds the second beat
  logic [1:0]          count;
  logic [TDATAW-1:0]   head_data;
  logic                head_last;
  logic [TDESTW-1:0]   head_dest;
  logic [TDATAW-1:0]   tail_data;
  logic                tail_last;
  logic [TDESTW-1:0]   tail_dest;

  logic                full;
  logic                push;
  logic                pop;

  assign cand = AXIS_S_TVALID & REQ_EN;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTRW    (PTRW)
  ) u_rr_arbiter (
    .req (cand),
    .ptr (rr_ptr),
    .sel (sel)
  );

  // Route the owner's stream fields through a one-hot mux; zero when idle.
  always_comb begin
    gidx     = '0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_dest  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx     = PTRW'(i);
        in_valid = AXIS_S_TVALID[i];
        in_data  = AXIS_S_TDATA[i*TDATAW +: TDATAW];
        in_last  = AXIS_S_TLAST[i];
        in_dest  = AXIS_S_TDEST[i*TDESTW +: TDESTW];
      end
    end
  end

  assign full = (count == 2'd2);
  // grant is non-zero only in LOCKED, so in_valid already implies ownership
  assign push = in_valid && !full && (state == LOCKED);
  assign pop  = (count != 2'd0) && AXIS_M_TREADY;

  // Grant FSM: pick an owner in IDLE, release it and advance the pointer on
  // the accepted TLAST beat.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            grant <= sel;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (push && in_last) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= (gidx == PTRW'(NUM_REQ-1)) ? '0 : gidx + PTRW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Two-entry FIFO; the head register is the output register, and a
  // simultaneous push and pop replaces the head in place.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count     <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      head_dest <= '0;
      tail_data <= '0;
      tail_last <= 1'b0;
      tail_dest <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_data <= in_data;
            head_last <= in_last;
            head_dest <= in_dest;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data <= in_data;
            head_last <= in_last;
            head_dest <= in_dest;
          end else if (push) begin
            tail_data <= in_data;
            tail_last <= in_last;
            tail_dest <= in_dest;
            count     <= 2'd2;
          end else if (pop) begin
            count     <= 2'd0;
          end
        end
        2'd2: begin
          // Full: no push can occur, only the tail moves up on a pop.
          if (pop) begin
            head_data <= tail_data;
            head_last <= tail_last;
            head_dest <= tail_dest;
            count     <= 2'd1;
          end
        end
        default: begin
          count <= 2'd0;
        end
      endcase
    end
  end

  assign AXIS_S_TREADY = grant & {NUM_REQ{!full}};
  assign AXIS_M_TVALID = (count != 2'd0);
  assign AXIS_M_TDATA  = head_data;
  assign AXIS_M_TLAST  = head_last;
  assign AXIS_M_TDEST  = head_dest;
  assign GRANT         = grant;
  assign BUSY          = (state == LOCKED) || (count != 2'd0);
  assign dbg_state     = state;
  assign dbg_rr_ptr    = rr_ptr;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter with two requesters.
module tb_noc_port_arbiter;
  import noc_pkg::*;

  localparam int W = 1 + 4 + 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- DUT ----------------
  logic        v0, v1, l0, l1;
  logic [31:0] d0, d1;
  logic [3:0]  t0, t1;
  logic [1:0]  req_en;
  logic [1:0]  s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [7:0]  s_tdest;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tdest;
  logic [1:0]  grant;
  logic        busy;
  arb_state_t  dbg_state;
  logic [0:0]  dbg_rr_ptr;

  assign s_tvalid = {v1, v0};
  assign s_tlast  = {l1, l0};
  assign s_tdata  = {d1, d0};
  assign s_tdest  = {t1, t0};

  noc_port_arbiter #(
    .TDATAW  (32),
    .TDESTW  (4),
    .NUM_REQ (2)
  ) dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .REQ_EN        (req_en),
    .AXIS_S_TVALID (s_tvalid),
    .AXIS_S_TREADY (s_tready),
    .AXIS_S_TDATA  (s_tdata),
    .AXIS_S_TLAST  (s_tlast),
    .AXIS_S_TDEST  (s_tdest),
    .AXIS_M_TVALID (m_tvalid),
    .AXIS_M_TREADY (m_tready),
    .AXIS_M_TDATA  (m_tdata),
    .AXIS_M_TLAST  (m_tlast),
    .AXIS_M_TDEST  (m_tdest),
    .GRANT         (grant),
    .BUSY          (busy),
    .dbg_state     (dbg_state),
    .dbg_rr_ptr    (dbg_rr_ptr)
  );

  // ---------------- scoreboard state ----------------
  int total;
  int bad;
  logic [W-1:0] exp_q[$];
  int in_cnt;
  int out_cnt;
  int g0_cyc;
  int g1_cyc;
  int out_cyc[64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a beat seen valid/ready at the negedge transfers on the
  // next rising edge.
  initial begin
    in_cnt  = 0;
    out_cnt = 0;
    g0_cyc  = 0;
    g1_cyc  = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((s_tvalid & s_tready) != 2'b00) in_cnt++;
        if (grant[0]) g0_cyc++;
        if (grant[1]) g1_cyc++;
        if (m_tvalid && m_tready) begin
          if (out_cnt < 64) out_cyc[out_cnt] = cyc;
          out_cnt++;
          check("out_q_empty", exp_q.size() == 0, 0);
          if (exp_q.size() != 0) check("out_beat", {m_tlast, m_tdest, m_tdata}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int r, input logic v, input logic [31:0] d, input logic l, input logic [3:0] t);
    if (r == 0) begin
      v0 = v; d0 = d; l0 = l; t0 = t;
    end else begin
      v1 = v; d1 = d; l1 = l; t1 = t;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that
  // accepted the last beat.
  task automatic send_pkt(input int r, input int n, input logic [31:0] base, input logic [3:0] dest);
    int  tmo;
    logic hs;
    tmo = 0;
    for (int i = 0; i < n; i++) begin
      drive(r, 1'b1, base + 32'(i), (i == n-1), dest);
      hs = 1'b0;
      while (!hs && tmo < 300) begin
        @(negedge clk);
        if (s_tready[r]) hs = 1'b1;
        else tmo++;
      end
      @(posedge clk);
      #1;
    end
    drive(r, 1'b0, 32'h0, 1'b0, 4'h0);
    check($sformatf("drv%0d_timeout", r), tmo >= 300, 0);
  endtask

  task automatic expect_pkt(input int n, input logic [31:0] base, input logic [3:0] dest);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n-1), dest, base + 32'(i)});
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n0, ob, ib, g0b, g1b, k;
    total    = 0;
    bad      = 0;
    m_tready = 1'b1;
    req_en   = 2'b11;
    apply_reset();

    // Reset values
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdest", m_tdest, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_rr_ptr", dbg_rr_ptr, 0);
    @(posedge clk);
    #1;

    // Single requester, 4 beats, latency and throughput
    expect_pkt(4, 32'h1, 4'h1);
    ob = out_cnt;
    n0 = cyc;
    send_pkt(0, 4, 32'h1, 4'h1);
    drain("t1_drain");
    check("t1_latency", out_cyc[ob] - n0, 2);
    check("t1_span", out_cyc[ob+3] - out_cyc[ob], 3);
    check("t1_grant_idle", grant, 0);
    check("t1_rr_ptr", dbg_rr_ptr, 1);
    check("t1_busy", busy, 0);

    // Both requesters streaming 3-beat packets: req0, req1, req0
    apply_reset();
    expect_pkt(3, 32'hA0, 4'h2);
    expect_pkt(3, 32'hB0, 4'h3);
    expect_pkt(3, 32'hA3, 4'h2);
    ob = out_cnt;
    fork
      begin
        send_pkt(0, 3, 32'hA0, 4'h2);
        send_pkt(0, 3, 32'hA3, 4'h2);
      end
      send_pkt(1, 3, 32'hB0, 4'h3);
    join
    drain("t2_drain");
    check("t2_gap01", out_cyc[ob+3] - out_cyc[ob+2], 2);
    check("t2_gap12", out_cyc[ob+6] - out_cyc[ob+5], 2);
    check("t2_span", out_cyc[ob+8] - out_cyc[ob], 10);

    // Backpressure: router stalls during a 6-beat packet
    apply_reset();
    m_tready = 1'b0;
    expect_pkt(6, 32'hC0, 4'h5);
    ib = in_cnt;
    ob = out_cnt;
    fork
      send_pkt(0, 6, 32'hC0, 4'h5);
      begin
        repeat (5) @(posedge clk);
        #2;
        check("t3_head_c5", m_tdata, 32'hC0);
        @(posedge clk);
        #2;
        check("t3_accepted", in_cnt - ib, 2);
        check("t3_s_tready", s_tready, 0);
        check("t3_m_tvalid", m_tvalid, 1);
        check("t3_head_c6", m_tdata, 32'hC0);
        check("t3_busy", busy, 1);
        m_tready = 1'b1;
      end
    join
    drain("t3_drain");
    check("t3_in_total", in_cnt - ib, 6);
    check("t3_out_total", out_cnt - ob, 6);

    // REQ_EN masking and mid-packet deassertion
    apply_reset();
    req_en = 2'b01;
    expect_pkt(3, 32'hD0, 4'h4);
    expect_pkt(1, 32'hE0, 4'h6);
    ib  = in_cnt;
    ob  = out_cnt;
    g1b = g1_cyc;
    fork
      send_pkt(0, 3, 32'hD0, 4'h4);
      send_pkt(1, 1, 32'hE0, 4'h6);
      begin
        k = 0;
        while (in_cnt < ib + 1 && k < 50) begin
          @(posedge clk);
          #2;
          k++;
        end
        req_en = 2'b00;
        k = 0;
        while (out_cnt < ob + 3 && k < 50) begin
          @(posedge clk);
          #2;
          k++;
        end
        repeat (3) @(posedge clk);
        #2;
        check("t4_req0_done", out_cnt - ob, 3);
        check("t4_grant_idle", grant, 0);
        check("t4_state_idle", dbg_state, IDLE);
        check("t4_req1_never", g1_cyc - g1b, 0);
        req_en = 2'b10;
      end
    join
    drain("t4_drain");
    req_en = 2'b11;

    // Reset mid-packet with two beats buffered
    apply_reset();
    m_tready = 1'b0;
    ib = in_cnt;
    drive(0, 1'b1, 32'hF00, 1'b0, 4'h7);
    repeat (5) @(posedge clk);
    #1;
    check("t5_buffered", in_cnt - ib, 2);
    check("t5_pre_m_tvalid", m_tvalid, 1);
    check("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_m_tvalid", m_tvalid, 0);
    check("t5_grant", grant, 0);
    check("t5_busy", busy, 0);
    check("t5_state", dbg_state, IDLE);
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    expect_pkt(2, 32'hF10, 4'h9);
    send_pkt(1, 2, 32'hF10, 4'h9);
    drain("t5_drain");

    // 1-beat packets from both requesters
    apply_reset();
    expect_pkt(1, 32'h60, 4'hA);
    expect_pkt(1, 32'h70, 4'hB);
    g0b = g0_cyc;
    g1b = g1_cyc;
    fork
      send_pkt(0, 1, 32'h60, 4'hA);
      send_pkt(1, 1, 32'h70, 4'hB);
    join
    drain("t6_drain");
    check("t6_g0_cycles", g0_cyc - g0b, 1);
    check("t6_g1_cycles", g1_cyc - g1b, 1);
    check("t6_rr_ptr", dbg_rr_ptr, 0);
    check("t6_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
